// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl
//
// Sequencer for an external cascade of 4-bit counter stages. A command
// (target value + periodic flag) is taken over a valid/ready handshake. The
// external counter is then cleared, and prescaled count-enable pulses are
// issued until the counter reads the target. At that point a one-cycle done
// pulse is produced. In periodic mode the sequence restarts automatically
// after every done. A stop request aborts any active operation. A counter
// wrap (enable issued while the ripple carry is high) ends the operation and
// sets a sticky error flag, which the next accepted command clears.
//
// Parameters
//   STAGES    number of cascaded 4-bit stages; counter width W = 4*STAGES
//   PRESCALE  clock cycles per count-enable pulse while running (>= 1)
//
// Ports
//   ck            in   clock, rising edge
//   rst           in   synchronous reset, active high
//   cmd_valid     in   command offered
//   cmd_ready     out  command accepted when cmd_valid & cmd_ready
//   cmd_target    in   [W] terminal count value
//   cmd_periodic  in   1 = restart after each done, 0 = one-shot
//   stop          in   abort the current operation (ignored when idle)
//   cnt_q         in   [W] current value of the external counter
//   cnt_rc        in   ripple carry of the external counter
//   cnt_clr       out  synchronous clear to the counter
//   cnt_en        out  count enable to the counter
//   busy          out  sequencer is not idle
//   done          out  one-cycle pulse when the target is reached
//   err           out  sticky wrap indication
// ---------------------------------------------------------------------------
module counter_seq_ctrl #(
    parameter int STAGES   = 1,
    parameter int PRESCALE = 1
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [4*STAGES-1:0]   cmd_target,
    input  logic                  cmd_periodic,
    input  logic                  stop,
    input  logic [4*STAGES-1:0]   cnt_q,
    input  logic                  cnt_rc,
    output logic                  cnt_clr,
    output logic                  cnt_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int W  = 4 * STAGES;
    // Prescaler needs at least one bit even when PRESCALE is 1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e         state;
    state_e         state_next;
    logic [PW-1:0]  presc;
    logic [PW-1:0]  presc_next;
    logic [W-1:0]   target_q;
    logic           periodic_q;
    logic           err_q;

    logic           accept;
    logic           at_target;
    logic           tick;
    logic           wrap;

    // Ready is decoded from state, but forced low while reset is held so no
    // command can slip in during the reset cycle.
    assign cmd_ready = (state == S_IDLE) & ~rst;
    assign accept    = cmd_valid & cmd_ready;

    // Unsigned W-bit equality; this is the only path from cnt_q to cnt_en.
    assign at_target = (cnt_q == target_q);
    assign tick      = (presc == PRESC_MAX);

    assign busy = (state != S_IDLE);
    assign err  = err_q;

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_next = state;
        presc_next = presc;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        done       = 1'b0;
        wrap       = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_CLEAR;
                end
            end

            S_CLEAR: begin
                // The prescaler restarts on every clear, so each run begins
                // with a full prescale period before its first enable.
                presc_next = '0;
                if (stop) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_clr    = 1'b1;
                    state_next = S_RUN;
                end
            end

            S_RUN: begin
                if (stop) begin
                    // Abort outranks both the target compare and the wrap
                    // check; err is left as it is.
                    state_next = S_IDLE;
                end else if (at_target) begin
                    // Compare wins over the prescaler: no enable is issued in
                    // the cycle the target is seen, so target 0 never counts.
                    state_next = S_DONE;
                end else begin
                    cnt_en     = tick;
                    presc_next = tick ? '0 : presc + PW'(1);
                    if (tick && cnt_rc) begin
                        // Counting past all-ones would wrap the counter.
                        wrap       = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end

            S_DONE: begin
                if (stop) begin
                    state_next = S_IDLE;
                end else begin
                    done       = 1'b1;
                    state_next = periodic_q ? S_CLEAR : S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, prescaler and command registers
    // -----------------------------------------------------------------------
    always_ff @(posedge ck) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state      <= S_IDLE;
            presc      <= '0;
            target_q   <= '0;
            periodic_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            presc <= presc_next;
            if (accept) begin
                target_q   <= cmd_target;
                periodic_q <= cmd_periodic;
                err_q      <= 1'b0;
            end else if (wrap) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_seq_ctrl
//
// Two sequencer instances (PRESCALE 1 and PRESCALE 4, one 4-bit stage each)
// drive behavioural counters. For every command the reference model computes,
// from the timing rules alone, the cycle of every clear, enable, done and
// return-to-idle event and queues them. A monitor pops the queue whenever a
// sequencer shows one of those events and compares lane, kind and cycle.
// ---------------------------------------------------------------------------
module tb_counter_seq_ctrl;

    localparam int W  = 4;
    localparam int P0 = 1;
    localparam int P1 = 4;

    typedef enum int {EV_CLR, EV_EN, EV_DONE, EV_IDLE} ev_kind_e;
    typedef enum int {ACT_NONE, ACT_STOP, ACT_RST, ACT_WRAP} act_e;
    typedef struct {
        int       lane;
        ev_kind_e kind;
        int       cyc;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   cmd_valid    = '0;
    logic [1:0]   cmd_periodic = '0;
    logic [1:0]   stop         = '0;
    logic [1:0]   rc_force     = '0;
    logic [W-1:0] cmd_target [2];
    logic [W-1:0] cnt_q      [2];
    logic [1:0]   cmd_ready;
    logic [1:0]   cnt_rc;
    logic [1:0]   cnt_clr;
    logic [1:0]   cnt_en;
    logic [1:0]   busy;
    logic [1:0]   done;
    logic [1:0]   err;

    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;
    ev_t exp_q[$];
    logic [1:0] busy_prev = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural external counters.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst || cnt_clr[i])  cnt_q[i] <= '0;
            else if (cnt_en[i])     cnt_q[i] <= cnt_q[i] + 4'd1;
        end
    end
    assign cnt_rc = {(cnt_q[1] == 4'hF), (cnt_q[0] == 4'hF)} | rc_force;

    counter_seq_ctrl #(.STAGES(1), .PRESCALE(P0)) u_dut0 (
        .ck(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_target(cmd_target[0]), .cmd_periodic(cmd_periodic[0]), .stop(stop[0]),
        .cnt_q(cnt_q[0]), .cnt_rc(cnt_rc[0]), .cnt_clr(cnt_clr[0]), .cnt_en(cnt_en[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    counter_seq_ctrl #(.STAGES(1), .PRESCALE(P1)) u_dut1 (
        .ck(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_target(cmd_target[1]), .cmd_periodic(cmd_periodic[1]), .stop(stop[1]),
        .cnt_q(cnt_q[1]), .cnt_rc(cnt_rc[1]), .cnt_clr(cnt_clr[1]), .cnt_en(cnt_en[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    task automatic observe(input int ln, input ev_kind_e k);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: lane %0d %s at cycle %0d, expected none", ln, k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("ev_lane(%s@%0d)", e.kind.name(), e.cyc), ln, e.lane);
            check($sformatf("ev_kind(%s@%0d)", e.kind.name(), e.cyc), k, e.kind);
            check($sformatf("ev_cycle(%s)", e.kind.name()), cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cnt_clr[i] === 1'b1)                     observe(i, EV_CLR);
            if (cnt_en[i]  === 1'b1)                     observe(i, EV_EN);
            if (done[i]    === 1'b1)                     observe(i, EV_DONE);
            if (busy_prev[i] === 1'b1 && busy[i] === 1'b0) observe(i, EV_IDLE);
        end
        busy_prev = busy;
    end

    // -------------------------------------------------------- reference model
    task automatic push_ev(input int ln, input ev_kind_e k, input int c);
        ev_t e;
        e.lane = ln;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Event timeline of one accepted command: clear the cycle after accept,
    // enables every p-th run cycle, done one cycle after the counter shows the
    // target. A stop at s suppresses everything from s on; reset or a wrap at
    // s keeps the events of cycle s. Either way busy drops at s+1.
    task automatic model_cmd(input int ln, input int k, input int t, input bit per,
                             input act_e act, input int s, output int end_cyc);
        int p;
        int cut;
        int c;
        int d;
        int e;
        p   = (ln == 0) ? P0 : P1;
        cut = (act == ACT_NONE) ? 32'h3FFF_FFFF : (act == ACT_STOP) ? s : s + 1;
        c   = k + 1;
        end_cyc = c;
        for (int run = 0; run < 64; run++) begin
            if (c >= cut) begin
                push_ev(ln, EV_IDLE, s + 1); end_cyc = s + 1; return;
            end
            push_ev(ln, EV_CLR, c);
            for (int j = 0; j < t; j++) begin
                e = c + 1 + j * p + (p - 1);
                if (e >= cut) begin
                    push_ev(ln, EV_IDLE, s + 1); end_cyc = s + 1; return;
                end
                push_ev(ln, EV_EN, e);
            end
            d = c + 1 + t * p + 1;
            if (d >= cut) begin
                push_ev(ln, EV_IDLE, s + 1); end_cyc = s + 1; return;
            end
            push_ev(ln, EV_DONE, d);
            if (!per) begin
                push_ev(ln, EV_IDLE, d + 1); end_cyc = d + 1; return;
            end
            c = d + 1;
        end
    endtask

    // -------------------------------------------------------------- stimulus
    task automatic run_cmd(input int ln, input int t, input bit per, input act_e act,
                           input int off, input bit junk);
        int k;
        int s;
        int end_cyc;
        @(posedge clk); #1;
        stop = '0; rc_force = '0;
        k = cyc;
        s = k + off;
        cmd_valid[ln]    = 1'b1;
        cmd_target[ln]   = W'(t);
        cmd_periodic[ln] = per;
        model_cmd(ln, k, t, per, act, s, end_cyc);
        @(negedge clk);
        check("ready_at_handshake", cmd_ready[ln], 1);
        forever begin
            @(posedge clk); #1;
            // Commands offered while busy must be ignored.
            cmd_valid[ln]    = junk && (cyc < end_cyc);
            cmd_target[ln]   = W'($urandom);
            cmd_periodic[ln] = 1'($urandom);
            stop[ln]         = (act == ACT_STOP) && (cyc == s);
            rc_force[ln]     = (act == ACT_WRAP) && (cyc == s);
            rst              = (act == ACT_RST) && (cyc == s || cyc == s + 1);
            if (act == ACT_RST && cyc == s + 1) cmd_valid[ln] = 1'b1;
            @(negedge clk);
            if (cyc == k + 1) check("err_cleared_on_accept", err[ln], 0);
            if (act == ACT_WRAP && cyc == s) check("wrap_cnt_q", cnt_q[ln], 9);
            if (act == ACT_RST && cyc == s + 1) begin
                check("rst_ready_low", cmd_ready[ln], 0);
                check("rst_outputs_zero", {cnt_clr[ln], cnt_en[ln], busy[ln], done[ln], err[ln]}, 0);
            end
            if (cyc == end_cyc) begin
                check("idle_busy_low", busy[ln], 0);
                if (act != ACT_RST) check("idle_ready_high", cmd_ready[ln], 1);
            end
            if (act == ACT_WRAP && cyc >= end_cyc) check("wrap_err_set", err[ln], 1);
            if (cyc == end_cyc + 1) begin
                if (act == ACT_RST) check("ready_after_rst", cmd_ready[ln], 1);
                break;
            end
        end
        @(posedge clk); #1;
        stop = '0; rc_force = '0; cmd_valid = '0;
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int p;
        bit per;
        act_e act;
        int off;
        cmd_target[0] = '0;
        cmd_target[1] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_ready_low", cmd_ready[i], 0);
            check("reset_outputs_zero", {cnt_clr[i], cnt_en[i], busy[i], done[i], err[i]}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 2'b11);

        // Directed scenarios
        run_cmd(0, 3,  1'b0, ACT_NONE, 0,  1'b0);  // basic one-shot
        run_cmd(0, 0,  1'b0, ACT_NONE, 0,  1'b0);  // target 0
        run_cmd(1, 2,  1'b1, ACT_STOP, 35, 1'b0);  // periodic, 3 dones, stop
        run_cmd(0, 10, 1'b0, ACT_STOP, 5,  1'b1);  // stop mid-run, valid held
        run_cmd(0, 15, 1'b0, ACT_WRAP, 11, 1'b0);  // forced wrap
        repeat (3) begin
            @(negedge clk);
            check("err_sticky", err[0], 1);
        end
        run_cmd(0, 10, 1'b0, ACT_RST,  5,  1'b0);  // reset mid-run
        run_cmd(1, 15, 1'b0, ACT_NONE, 0,  1'b1);  // full count, rc at compare

        // Randomized commands on both lanes
        for (int n = 0; n < 36; n++) begin
            int ln;
            ln  = n % 2;
            p   = (ln == 0) ? P0 : P1;
            t   = $urandom_range(0, 15);
            per = 1'($urandom_range(0, 1));
            if (per) begin
                act = ACT_STOP;
                off = $urandom_range(2, 3 * (t * p + 3));
            end else begin
                act = ($urandom_range(0, 1) != 0) ? ACT_STOP : ACT_NONE;
                off = $urandom_range(1, t * p + 4);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_cmd(ln, t, per, act, off, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        check("final_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
